data_ram_ctrl: RTL and testbench

Parametrised successor to the single-port data RAM on the datapath's load/store path. Adds a configurable base address, depth and width, byte-enable writes, a registered read with a valid strobe, write-first read-during-write, address-fault detection, and a clear-on-reset sweep that reports readiness. Sits between the LSU and data memory; the CPU stalls on Ready=0.

---
 rtl/data_ram_pkg.sv | 28 ++
 rtl/data_ram_addr_decode.sv | 29 ++
 rtl/data_ram_ctrl.sv | 163 ++++++++++++++++
 tb/tb_data_ram_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/data_ram_pkg.sv
// Shared types and helpers for the data RAM controller: FSM state enum and a byte-merge function.
package data_ram_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    // Widest word the merge helper handles; callers cast their word to and from this width.
    localparam int MERGE_W  = 256;
    localparam int MERGE_BE = MERGE_W / 8;

    function automatic logic [MERGE_W-1:0] byte_merge(
        input logic [MERGE_W-1:0]  oldWord,
        input logic [MERGE_W-1:0]  newWord,
        input logic [MERGE_BE-1:0] byteEn
    );
        logic [MERGE_W-1:0] merged;
        merged = oldWord;
        for (int i = 0; i < MERGE_BE; i++) begin
            if (byteEn[i]) begin
                merged[8*i +: 8] = newWord[8*i +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/data_ram_addr_decode.sv
// Combinational byte-address decode: checks range and word alignment against the RAM window
// and produces the word index.
module data_ram_addr_decode #(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    parameter int                DEPTH     = 256,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h1000
) (
    input  logic [ADDR_W-1:0]        i_a,
    output logic                     o_legal,
    output logic [$clog2(DEPTH)-1:0] o_idx
);

    localparam int                BYTES      = DATA_W / 8;
    localparam int                LSB        = $clog2(BYTES);
    localparam int                IDX_W      = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] SPAN       = ADDR_W'(DEPTH * BYTES);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(BYTES - 1);

    logic [ADDR_W-1:0] w_off;

    // Offset wraps for addresses below the base, so the explicit lower-bound test is needed.
    always_comb begin
        w_off   = i_a - BASE_ADDR;
        o_legal = (i_a >= BASE_ADDR) && (w_off < SPAN) && ((w_off & ALIGN_MASK) == '0);
        o_idx   = w_off[LSB +: IDX_W];
    end

endmodule

// File: rtl/data_ram_ctrl.sv
// Parametrised single-port data RAM controller with byte enables, registered write-first reads,
// address-fault strobe and a clear sweep after reset. Optional counters under DATA_RAM_STATS_EN.
module data_ram_ctrl
    import data_ram_pkg::*;
#(
    parameter int                DATA_W    = 32,
    parameter int                ADDR_W    = 32,
    parameter int                DEPTH     = 256,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h1000
`ifdef DATA_RAM_STATS_EN
    ,
    parameter int                COUNT_W   = 16
`endif
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                MemWrite,
    input  logic                MemRead,
    input  logic [ADDR_W-1:0]   A,
    input  logic [DATA_W-1:0]   WriteData,
    input  logic [DATA_W/8-1:0] ByteEn,
    output logic [DATA_W-1:0]   ReadData,
    output logic                ReadValid,
    output logic                Ready,
    output logic                AddrFault
`ifdef DATA_RAM_STATS_EN
    ,
    output logic [COUNT_W-1:0]  RdCount,
    output logic [COUNT_W-1:0]  WrCount,
    output logic [COUNT_W-1:0]  FaultCount
`endif
);

    localparam int IDX_W = $clog2(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    state_t            r_state;
    logic [IDX_W-1:0]  r_clrPtr;
    logic [DATA_W-1:0] r_readData;
    logic              r_readValid;
    logic              r_addrFault;

    state_t            w_nextState;
    logic              w_legal;
    logic [IDX_W-1:0]  w_idx;
    logic              w_clrWe;
    logic              w_wrEn;
    logic              w_rdEn;
    logic              w_fault;
    logic [DATA_W-1:0] w_merged;

    data_ram_addr_decode #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .BASE_ADDR (BASE_ADDR)
    ) u_decode (
        .i_a     (A),
        .o_legal (w_legal),
        .o_idx   (w_idx)
    );

    always_comb begin
        w_merged = DATA_W'(byte_merge(MERGE_W'(r_mem[w_idx]), MERGE_W'(WriteData),
                                      MERGE_BE'(ByteEn)));
    end

    // Requests are only decoded in RUN; CLEAR owns the write port for the sweep.
    always_comb begin
        w_nextState = r_state;
        w_clrWe     = 1'b0;
        w_wrEn      = 1'b0;
        w_rdEn      = 1'b0;
        w_fault     = 1'b0;
        Ready       = 1'b0;
        case (r_state)
            CLEAR: begin
                w_clrWe = 1'b1;
                if (r_clrPtr == IDX_W'(DEPTH - 1)) begin
                    w_nextState = RUN;
                end
            end
            RUN: begin
                Ready   = 1'b1;
                w_wrEn  = MemWrite & w_legal;
                w_rdEn  = MemRead & w_legal;
                w_fault = (MemRead | MemWrite) & ~w_legal;
            end
            default: w_nextState = CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= CLEAR;
            r_clrPtr <= '0;
        end else begin
            r_state <= w_nextState;
            if (w_clrWe) begin
                r_clrPtr <= r_clrPtr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (w_clrWe) begin
                r_mem[r_clrPtr] <= '0;
            end else if (w_wrEn) begin
                r_mem[w_idx] <= w_merged;
            end
        end
    end

    // A simultaneous write to the same word returns the merged value (write-first).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_readData  <= '0;
            r_readValid <= 1'b0;
            r_addrFault <= 1'b0;
        end else begin
            r_readValid <= w_rdEn;
            r_addrFault <= w_fault;
            if (w_rdEn) begin
                r_readData <= w_wrEn ? w_merged : r_mem[w_idx];
            end
        end
    end

    assign ReadData  = r_readData;
    assign ReadValid = r_readValid;
    assign AddrFault = r_addrFault;

`ifdef DATA_RAM_STATS_EN
    logic [COUNT_W-1:0] r_rdCount;
    logic [COUNT_W-1:0] r_wrCount;
    logic [COUNT_W-1:0] r_faultCount;

    // Counters saturate rather than wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdCount    <= '0;
            r_wrCount    <= '0;
            r_faultCount <= '0;
        end else begin
            if (w_rdEn && (r_rdCount != '1)) begin
                r_rdCount <= r_rdCount + 1'b1;
            end
            if (w_wrEn && (r_wrCount != '1)) begin
                r_wrCount <= r_wrCount + 1'b1;
            end
            if (w_fault && (r_faultCount != '1)) begin
                r_faultCount <= r_faultCount + 1'b1;
            end
        end
    end

    assign RdCount    = r_rdCount;
    assign WrCount    = r_wrCount;
    assign FaultCount = r_faultCount;
`endif

endmodule

// File: tb/tb_data_ram_ctrl.sv
// Directed self-checking bench for data_ram_ctrl at default parameters
// (also covers the DATA_RAM_STATS_EN counters when that macro is defined).
module tb_data_ram_ctrl;

    logic        clk;
    logic        rst;
    logic        MemWrite;
    logic        MemRead;
    logic [31:0] A;
    logic [31:0] WriteData;
    logic [3:0]  ByteEn;
    logic [31:0] ReadData;
    logic        ReadValid;
    logic        Ready;
    logic        AddrFault;
`ifdef DATA_RAM_STATS_EN
    logic [15:0] RdCount;
    logic [15:0] WrCount;
    logic [15:0] FaultCount;
`endif

    int checkCount = 0;
    int failCount  = 0;

    data_ram_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .MemWrite   (MemWrite),
        .MemRead    (MemRead),
        .A          (A),
        .WriteData  (WriteData),
        .ByteEn     (ByteEn),
        .ReadData   (ReadData),
        .ReadValid  (ReadValid),
        .Ready      (Ready),
        .AddrFault  (AddrFault)
`ifdef DATA_RAM_STATS_EN
        ,
        .RdCount    (RdCount),
        .WrCount    (WrCount),
        .FaultCount (FaultCount)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drives one request for exactly one rising edge; returns at the following falling edge.
    task automatic applyStimulus(input logic wr, input logic rd, input logic [31:0] addr,
                                 input logic [31:0] data, input logic [3:0] be);
        MemWrite  = wr;
        MemRead   = rd;
        A         = addr;
        WriteData = data;
        ByteEn    = be;
        @(posedge clk);
        @(negedge clk);
        MemWrite = 1'b0;
        MemRead  = 1'b0;
    endtask

    task automatic test_reset();
        int cycles;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checkCount += 4;
        if (Ready !== 1'b0) begin failCount++; $display("[TB] FAIL reset_ready got %b expected 0", Ready); end
        if (ReadValid !== 1'b0) begin failCount++; $display("[TB] FAIL reset_valid got %b expected 0", ReadValid); end
        if (AddrFault !== 1'b0) begin failCount++; $display("[TB] FAIL reset_fault got %b expected 0", AddrFault); end
        if (ReadData !== 32'h0) begin failCount++; $display("[TB] FAIL reset_rdata got %h expected 00000000", ReadData); end
        cycles = 0;
        while (Ready !== 1'b1 && cycles < 300) begin
            @(posedge clk);
            @(negedge clk);
            cycles++;
        end
        checkCount++;
        if (cycles != 256) begin failCount++; $display("[TB] FAIL sweep_len got %0d expected 256", cycles); end
        applyStimulus(1'b0, 1'b1, 32'h1000, 32'h0, 4'h0);
        checkCount += 2;
        if (ReadValid !== 1'b1) begin failCount++; $display("[TB] FAIL clr_rd0_valid got %b expected 1", ReadValid); end
        if (ReadData !== 32'h0) begin failCount++; $display("[TB] FAIL clr_rd0_data got %h expected 00000000", ReadData); end
        applyStimulus(1'b0, 1'b1, 32'h13FC, 32'h0, 4'h0);
        checkCount += 2;
        if (ReadValid !== 1'b1) begin failCount++; $display("[TB] FAIL clr_rdlast_valid got %b expected 1", ReadValid); end
        if (ReadData !== 32'h0) begin failCount++; $display("[TB] FAIL clr_rdlast_data got %h expected 00000000", ReadData); end
        @(posedge clk);
        @(negedge clk);
        checkCount++;
        if (ReadValid !== 1'b0) begin failCount++; $display("[TB] FAIL idle_valid got %b expected 0", ReadValid); end
    endtask

    task automatic test_word_rw();
        applyStimulus(1'b1, 1'b0, 32'h1000, 32'h000013FF, 4'hF);
        checkCount++;
        if (ReadValid !== 1'b0) begin failCount++; $display("[TB] FAIL wr_no_valid got %b expected 0", ReadValid); end
        applyStimulus(1'b1, 1'b0, 32'h1004, 32'h00000100, 4'hF);
        // Two reads back to back, no idle cycle between them.
        applyStimulus(1'b0, 1'b1, 32'h1000, 32'h0, 4'h0);
        checkCount += 2;
        if (ReadValid !== 1'b1) begin failCount++; $display("[TB] FAIL rd1000_valid got %b expected 1", ReadValid); end
        if (ReadData !== 32'h000013FF) begin failCount++; $display("[TB] FAIL rd1000_data got %h expected 000013ff", ReadData); end
        applyStimulus(1'b0, 1'b1, 32'h1004, 32'h0, 4'h0);
        checkCount += 2;
        if (ReadValid !== 1'b1) begin failCount++; $display("[TB] FAIL rd1004_valid got %b expected 1", ReadValid); end
        if (ReadData !== 32'h00000100) begin failCount++; $display("[TB] FAIL rd1004_data got %h expected 00000100", ReadData); end
        @(posedge clk);
        @(negedge clk);
        checkCount += 2;
        if (ReadValid !== 1'b0) begin failCount++; $display("[TB] FAIL hold_valid got %b expected 0", ReadValid); end
        if (ReadData !== 32'h00000100) begin failCount++; $display("[TB] FAIL hold_data got %h expected 00000100", ReadData); end
    endtask

    task automatic test_byte_en();
        applyStimulus(1'b1, 1'b0, 32'h1008, 32'hAABBCCDD, 4'hF);
        applyStimulus(1'b1, 1'b0, 32'h1008, 32'h11223344, 4'b0101);
        applyStimulus(1'b0, 1'b1, 32'h1008, 32'h0, 4'h0);
        checkCount++;
        if (ReadData !== 32'hAA22CC44) begin failCount++; $display("[TB] FAIL byte_merge got %h expected aa22cc44", ReadData); end
        applyStimulus(1'b1, 1'b0, 32'h1008, 32'hFFFFFFFF, 4'h0);
        checkCount++;
        if (AddrFault !== 1'b0) begin failCount++; $display("[TB] FAIL be0_fault got %b expected 0", AddrFault); end
        applyStimulus(1'b0, 1'b1, 32'h1008, 32'h0, 4'h0);
        checkCount++;
        if (ReadData !== 32'hAA22CC44) begin failCount++; $display("[TB] FAIL be0_noop got %h expected aa22cc44", ReadData); end
    endtask

    task automatic test_write_first();
        applyStimulus(1'b1, 1'b1, 32'h100C, 32'hDEADBEEF, 4'hF);
        checkCount += 2;
        if (ReadValid !== 1'b1) begin failCount++; $display("[TB] FAIL wf_valid got %b expected 1", ReadValid); end
        if (ReadData !== 32'hDEADBEEF) begin failCount++; $display("[TB] FAIL wf_full got %h expected deadbeef", ReadData); end
        applyStimulus(1'b1, 1'b1, 32'h100C, 32'h11111111, 4'b0011);
        checkCount++;
        if (ReadData !== 32'hDEAD1111) begin failCount++; $display("[TB] FAIL wf_partial got %h expected dead1111", ReadData); end
    endtask

    task automatic test_faults();
        applyStimulus(1'b0, 1'b1, 32'h0FFC, 32'h0, 4'h0);
        checkCount += 3;
        if (AddrFault !== 1'b1) begin failCount++; $display("[TB] FAIL flt_below got %b expected 1", AddrFault); end
        if (ReadValid !== 1'b0) begin failCount++; $display("[TB] FAIL flt_below_valid got %b expected 0", ReadValid); end
        if (ReadData !== 32'hDEAD1111) begin failCount++; $display("[TB] FAIL flt_hold got %h expected dead1111", ReadData); end
        applyStimulus(1'b1, 1'b0, 32'h1400, 32'hCAFEF00D, 4'hF);
        checkCount++;
        if (AddrFault !== 1'b1) begin failCount++; $display("[TB] FAIL flt_above got %b expected 1", AddrFault); end
        applyStimulus(1'b0, 1'b1, 32'h1002, 32'h0, 4'h0);
        checkCount += 2;
        if (AddrFault !== 1'b1) begin failCount++; $display("[TB] FAIL flt_align got %b expected 1", AddrFault); end
        if (ReadValid !== 1'b0) begin failCount++; $display("[TB] FAIL flt_align_valid got %b expected 0", ReadValid); end
        @(posedge clk);
        @(negedge clk);
        checkCount++;
        if (AddrFault !== 1'b0) begin failCount++; $display("[TB] FAIL flt_pulse got %b expected 0", AddrFault); end
        applyStimulus(1'b0, 1'b1, 32'h1000, 32'h0, 4'h0);
        checkCount++;
        if (ReadData !== 32'h000013FF) begin failCount++; $display("[TB] FAIL flt_mem0 got %h expected 000013ff", ReadData); end
        applyStimulus(1'b0, 1'b1, 32'h13FC, 32'h0, 4'h0);
        checkCount += 2;
        if (AddrFault !== 1'b0) begin failCount++; $display("[TB] FAIL last_word_fault got %b expected 0", AddrFault); end
        if (ReadData !== 32'h0) begin failCount++; $display("[TB] FAIL last_word_data got %h expected 00000000", ReadData); end
`ifdef DATA_RAM_STATS_EN
        checkCount++;
        if (FaultCount !== 16'd3) begin failCount++; $display("[TB] FAIL fault_count got %0d expected 3", FaultCount); end
`endif
    endtask

    task automatic test_reset_mid();
        int  cycles;
        bit  strobeSeen;
        applyStimulus(1'b1, 1'b0, 32'h1010, 32'h00000005, 4'hF);
        applyStimulus(1'b0, 1'b1, 32'h1010, 32'h0, 4'h0);
        checkCount++;
        if (ReadData !== 32'h5) begin failCount++; $display("[TB] FAIL mid_pre got %h expected 00000005", ReadData); end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (100) begin
            @(posedge clk);
            @(negedge clk);
        end
        checkCount++;
        if (Ready !== 1'b0) begin failCount++; $display("[TB] FAIL mid_sweep_ready got %b expected 0", Ready); end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        cycles = 0;
        strobeSeen = 1'b0;
        while (Ready !== 1'b1 && cycles < 300) begin
            MemRead   = 1'b1;
            MemWrite  = 1'b1;
            WriteData = 32'h00000077;
            ByteEn    = 4'hF;
            A         = cycles[0] ? 32'h0FFC : 32'h1010;
            @(posedge clk);
            @(negedge clk);
            if (ReadValid !== 1'b0 || AddrFault !== 1'b0) strobeSeen = 1'b1;
            cycles++;
        end
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        checkCount += 2;
        if (cycles != 256) begin failCount++; $display("[TB] FAIL mid_sweep_len got %0d expected 256", cycles); end
        if (strobeSeen !== 1'b0) begin failCount++; $display("[TB] FAIL clear_ignored got %b expected 0", strobeSeen); end
`ifdef DATA_RAM_STATS_EN
        checkCount++;
        if (RdCount !== 16'd0) begin failCount++; $display("[TB] FAIL rdcount_clr got %0d expected 0", RdCount); end
`endif
        applyStimulus(1'b0, 1'b1, 32'h1010, 32'h0, 4'h0);
        checkCount += 2;
        if (ReadValid !== 1'b1) begin failCount++; $display("[TB] FAIL mid_post_valid got %b expected 1", ReadValid); end
        if (ReadData !== 32'h0) begin failCount++; $display("[TB] FAIL mid_post_data got %h expected 00000000", ReadData); end
    endtask

    initial begin
        rst       = 1'b0;
        MemWrite  = 1'b0;
        MemRead   = 1'b0;
        A         = 32'h0;
        WriteData = 32'h0;
        ByteEn    = 4'h0;
        test_reset();
        test_word_rw();
        test_byte_en();
        test_write_first();
        test_faults();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
